// File: rtl/dlx_pkg.sv
// Shared state encodings and requester IDs for the DLX memory arbiter.
// DLX_ARB_ROUND_ROBIN_EN (optional) switches dlx_arb_pick to round-robin ties.
package dlx_pkg;

  localparam int ARB_W = 2;

  typedef enum logic [ARB_W-1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_e;

  localparam logic REQ_CPU  = 1'b0;
  localparam logic REQ_HOST = 1'b1;

endpackage

// File: rtl/dlx_arb_pick.sv
// Combinational grantee selection for the two-port memory arbiter.
// Macro DLX_ARB_ROUND_ROBIN_EN: ties go to the port not granted last.
module dlx_arb_pick
  import dlx_pkg::*;
(
  input  logic cpu_req,
  input  logic host_req,
  input  logic last_grant,
  output logic grantee
);

`ifdef DLX_ARB_ROUND_ROBIN_EN
  logic tie_host;
  assign tie_host = (last_grant == REQ_CPU);
  assign grantee  = (host_req & (~cpu_req | tie_host))
                  ? REQ_HOST : REQ_CPU;
`else
  logic unused_last;
  assign unused_last = last_grant;
  assign grantee     = (host_req & ~cpu_req)
                     ? REQ_HOST : REQ_CPU;
`endif

endmodule

// File: rtl/dlx_mem_arbiter.sv
// CPU/host shared-memory arbiter: IDLE -> ACCESS (WAIT_CYCLES) -> DONE.
// Macro DLX_ARB_ROUND_ROBIN_EN enables round-robin tie breaking.
module dlx_mem_arbiter
  import dlx_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_mr,
  input  logic              cpu_mw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_busy,
  input  logic              host_mr,
  input  logic              host_mw,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_busy,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ARB_W-1:0]  arb_state,
  output logic              grant_host
);

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  arb_state_e        state;
  logic [3:0]        cnt;
  logic              cpu_req;
  logic              host_req;
  logic              pick;
  logic              pick_wr;
  logic [ADDR_W-1:0] pick_addr;
  logic [DATA_W-1:0] pick_wdata;
  logic              in_done;

  assign cpu_req  = cpu_mr | cpu_mw;
  assign host_req = host_mr | host_mw;

  dlx_arb_pick u_pick (
    .cpu_req    (cpu_req),
    .host_req   (host_req),
    .last_grant (grant_host),
    .grantee    (pick)
  );

  // Write wins when a port raises mr and mw together.
  always_comb begin
    pick_wr    = cpu_mw;
    pick_addr  = cpu_addr;
    pick_wdata = cpu_wdata;
    if (pick == REQ_HOST) begin
      pick_wr    = host_mw;
      pick_addr  = host_addr;
      pick_wdata = host_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB_IDLE;
      cnt        <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rdata  <= '0;
      host_rdata <= '0;
      grant_host <= 1'b0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (cpu_req | host_req) begin
            state      <= ARB_ACCESS;
            cnt        <= CNT_LOAD;
            grant_host <= pick;
            mem_rd     <= ~pick_wr;
            mem_wr     <= pick_wr;
            mem_addr   <= pick_addr;
            mem_wdata  <= pick_wdata;
          end
        end
        ARB_ACCESS: begin
          if (cnt == 4'd0) begin
            state  <= ARB_DONE;
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            if (mem_rd) begin
              if (grant_host == REQ_HOST)
                host_rdata <= mem_rdata;
              else
                cpu_rdata  <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ARB_DONE: state <= ARB_IDLE;
        default:  state <= ARB_IDLE;
      endcase
    end
  end

  assign in_done   = (state == ARB_DONE);
  assign cpu_busy  = cpu_req
                   & ~(in_done & (grant_host == REQ_CPU));
  assign host_busy = host_req
                   & ~(in_done & (grant_host == REQ_HOST));
  assign arb_state = state;

endmodule

// File: tb/tb_dlx_mem_arbiter.sv
// Self-checking bench for dlx_mem_arbiter (WAIT_CYCLES=2 and =1 instances).
// Build with DLX_ARB_ROUND_ROBIN_EN to check the round-robin tie case.
module tb_dlx_mem_arbiter;
  import dlx_pkg::*;

  localparam int WC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_mr, cpu_mw, host_mr, host_mw;
  logic [15:0] cpu_addr, host_addr, mem_addr;
  logic [31:0] cpu_wdata, host_wdata, mem_wdata;
  logic [31:0] cpu_rdata, host_rdata, mem_rdata;
  logic        cpu_busy, host_busy, mem_rd, mem_wr, grant_host;
  logic [1:0]  arb_state;

  logic        b_cpu_mr, b_cpu_mw, b_host_mr, b_host_mw;
  logic [15:0] b_cpu_addr, b_host_addr, b_mem_addr;
  logic [31:0] b_cpu_wdata, b_host_wdata, b_mem_wdata;
  logic [31:0] b_cpu_rdata, b_host_rdata, b_mem_rdata;
  logic        b_cpu_busy, b_host_busy, b_mem_rd, b_mem_wr;
  logic        b_grant_host;
  logic [1:0]  b_arb_state;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [15:0] a);
    if (a == 16'h0005) return 32'hDEADBEEF;
    return {~a, a};
  endfunction

  assign mem_rdata   = mem_f(mem_addr);
  assign b_mem_rdata = mem_f(b_mem_addr);

  dlx_mem_arbiter #(.WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset(reset),
    .cpu_mr(cpu_mr), .cpu_mw(cpu_mw),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy),
    .host_mr(host_mr), .host_mw(host_mw),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_busy(host_busy),
    .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .arb_state(arb_state), .grant_host(grant_host)
  );

  dlx_mem_arbiter #(.WAIT_CYCLES(1)) dut_b (
    .clk(clk), .reset(reset),
    .cpu_mr(b_cpu_mr), .cpu_mw(b_cpu_mw),
    .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_rdata(b_cpu_rdata), .cpu_busy(b_cpu_busy),
    .host_mr(b_host_mr), .host_mw(b_host_mw),
    .host_addr(b_host_addr), .host_wdata(b_host_wdata),
    .host_rdata(b_host_rdata), .host_busy(b_host_busy),
    .mem_rd(b_mem_rd), .mem_wr(b_mem_wr),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata),
    .arb_state(b_arb_state), .grant_host(b_grant_host)
  );

  typedef struct {
    logic        host;
    logic        mr;
    logic        mw;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        drop;
    int          n_rd;
    int          n_wr;
    logic [31:0] cpu_rd;
    logic [31:0] host_rd;
  } txn_t;

  typedef struct {
    int          lat;
    int          n_rd;
    int          n_wr;
    logic [31:0] cpu_rd;
    logic [31:0] host_rd;
  } exp_t;

  typedef struct {
    logic        host;
    int          cyc;
    logic [31:0] rd;
  } tie_t;

  txn_t        tbl[6];
  exp_t        sb[$];
  tie_t        sb_tie[$];
  logic [31:0] sb_b[$];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timeout", name);
  endtask

  task automatic drive(input logic h, input logic mr,
                       input logic mw, input logic [15:0] a,
                       input logic [31:0] d);
    if (h) begin
      host_mr = mr; host_mw = mw;
      host_addr = a; host_wdata = d;
    end else begin
      cpu_mr = mr; cpu_mw = mw;
      cpu_addr = a; cpu_wdata = d;
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
  endtask

  task automatic run_txn(input txn_t t);
    exp_t e;
    int   nrd = 0;
    int   nwr = 0;
    bit   done = 0;
    logic lvl = 1'b1;
    logic bz;
    e.lat = WC + 1; e.n_rd = t.n_rd; e.n_wr = t.n_wr;
    e.cpu_rd = t.cpu_rd; e.host_rd = t.host_rd;
    sb.push_back(e);
    drive(t.host, t.mr, t.mw, t.addr, t.wdata);
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      bz = t.host ? host_busy : cpu_busy;
      if (mem_rd) nrd++;
      if (mem_wr) nwr++;
      if (mem_rd | mem_wr) begin
        chk("mem_addr", {16'h0, mem_addr}, {16'h0, t.addr});
        chk("mem_wdata", mem_wdata, t.wdata);
      end
      if (arb_state == 2'd2) begin
        done = 1;
        e = sb.pop_front();
        chk("latency", 32'(c), 32'(e.lat));
        chk("busy_done", {31'h0, bz}, 32'h0);
        chk("grant_host", {31'h0, grant_host}, {31'h0, t.host});
        chk("n_rd", 32'(nrd), 32'(e.n_rd));
        chk("n_wr", 32'(nwr), 32'(e.n_wr));
        chk("cpu_rdata", cpu_rdata, e.cpu_rd);
        chk("host_rdata", host_rdata, e.host_rd);
      end else begin
        chk("busy", {31'h0, bz}, {31'h0, lvl});
      end
      @(posedge clk); #1;
      if (c == 0) begin
        if (t.drop) begin
          drive(t.host, 1'b0, 1'b0, ~t.addr, ~t.wdata);
          lvl = 1'b0;
        end else begin
          drive(t.host, t.mr, t.mw, ~t.addr, ~t.wdata);
        end
      end
    end
    if (!done) begin
      timeout("txn_done");
      void'(sb.pop_front());
    end
    idle();
  endtask

  initial begin
    tie_t te;
    int   k;
    tbl[0] = '{1'b0, 1'b1, 1'b0, 16'h0005, 32'h0, 1'b0,
               2, 0, 32'hDEADBEEF, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 16'h0010, 32'h12345678, 1'b0,
               0, 2, 32'hDEADBEEF, 32'h0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 16'h0040, 32'hCAFEF00D, 1'b0,
               0, 2, 32'hDEADBEEF, 32'h0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 16'h0022, 32'h0, 1'b0,
               2, 0, 32'hDEADBEEF, 32'hFFDD0022};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 16'h0033, 32'h0, 1'b1,
               2, 0, 32'hFFCC0033, 32'hFFDD0022};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 16'hFFFF, 32'h0, 1'b0,
               2, 0, 32'h0000FFFF, 32'hFFDD0022};

    idle();
    b_cpu_mr = 0; b_cpu_mw = 0; b_cpu_addr = 0; b_cpu_wdata = 0;
    b_host_mr = 0; b_host_mw = 0; b_host_addr = 0; b_host_wdata = 0;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_state", {30'h0, arb_state}, 32'h0);
    chk("rst_strobes", {30'h0, mem_rd, mem_wr}, 32'h0);
    chk("rst_addr", {16'h0, mem_addr}, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_host_rdata", host_rdata, 32'h0);
    chk("rst_grant", {31'h0, grant_host}, 32'h0);
    chk("rst_busy", {30'h0, cpu_busy, host_busy}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_txn(tbl[i]);

    // Simultaneous requests; last grant was CPU.
`ifdef DLX_ARB_ROUND_ROBIN_EN
    sb_tie.push_back('{1'b1, 3, 32'hFDFD0202});
    sb_tie.push_back('{1'b0, 7, 32'hFEFE0101});
`else
    sb_tie.push_back('{1'b0, 3, 32'hFEFE0101});
    sb_tie.push_back('{1'b1, 7, 32'hFDFD0202});
`endif
    drive(1'b0, 1'b1, 1'b0, 16'h0101, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 16'h0202, 32'h0);
    for (int c = 0; c < 16 && sb_tie.size() > 0; c++) begin
      @(negedge clk);
      if (arb_state == 2'd2) begin
        te = sb_tie.pop_front();
        chk("tie_grant", {31'h0, grant_host}, {31'h0, te.host});
        chk("tie_cycle", 32'(c), 32'(te.cyc));
        chk("tie_rdata", te.host ? host_rdata : cpu_rdata, te.rd);
        chk("tie_busy", {31'h0, te.host ? host_busy : cpu_busy}, 32'h0);
        @(posedge clk); #1;
        drive(te.host, 1'b0, 1'b0, 16'h0, 32'h0);
      end else begin
        @(posedge clk); #1;
      end
    end
    if (sb_tie.size() > 0) timeout("tie_done");
    idle();

    // Reset during the first ACCESS cycle aborts the read.
    drive(1'b0, 1'b1, 1'b0, 16'h0005, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rstacc_in_access", {30'h0, arb_state}, 32'h1);
    chk("rstacc_rd_before", {31'h0, mem_rd}, 32'h1);
    @(posedge clk); #1;
    reset = 1'b0;
    idle();
    @(negedge clk);
    chk("rstacc_state", {30'h0, arb_state}, 32'h0);
    chk("rstacc_strobes", {30'h0, mem_rd, mem_wr}, 32'h0);
    chk("rstacc_cpu_rdata", cpu_rdata, 32'h0);
    chk("rstacc_grant", {31'h0, grant_host}, 32'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rstacc_no_done", {30'h0, arb_state}, 32'h0);
      chk("rstacc_rdata_hold", cpu_rdata, 32'h0);
    end

    // WAIT_CYCLES=1 back-to-back CPU reads: DONE every 3rd cycle.
    @(posedge clk); #1;
    sb_b.push_back(32'hDEADBEEF);
    sb_b.push_back(32'hEDCB1234);
    sb_b.push_back(32'hFFFF0000);
    sb_b.push_back(32'h5432ABCD);
    b_cpu_mr = 1'b1;
    b_cpu_addr = 16'h0005;
    k = 0;
    for (int c = 0; c < 20 && sb_b.size() > 0; c++) begin
      @(negedge clk);
      chk("b_strobe_wr", {31'h0, b_mem_wr}, 32'h0);
      if (!b_cpu_busy) begin
        chk("b_cycle", 32'(c), 32'(2 + 3 * k));
        chk("b_rdata", b_cpu_rdata, sb_b.pop_front());
        k++;
        @(posedge clk); #1;
        unique case (k)
          1: b_cpu_addr = 16'h1234;
          2: b_cpu_addr = 16'h0000;
          3: b_cpu_addr = 16'hABCD;
          default: b_cpu_mr = 1'b0;
        endcase
      end else begin
        @(posedge clk); #1;
      end
    end
    if (sb_b.size() > 0) timeout("b_done");
    b_cpu_mr = 1'b0;

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
